// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encoding and endpoint state constants,
// common to the SPI master and slave.
package spi_pkg;

  localparam int SPI_W = 8;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  // Mode is {CPOL, CPHA}.
  function automatic logic mode_cpol(input spi_mode_e m);
    return m[1];
  endfunction

  function automatic logic mode_cpha(input spi_mode_e m);
    return m[0];
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Pin-level and byte-level signals of the SPI slave endpoint.
interface spi_slave_if;
  import spi_pkg::*;

  logic             cs;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic             miso_oe;
  logic             CPOL;
  logic             CPHA;
  logic [SPI_W-1:0] data_tx;
  logic             tx_load;
  logic [SPI_W-1:0] data_rx;
  logic             rx_valid;
  logic             rx_abort;
  logic             busy;

  modport slave (
    input  cs, sclk, mosi, CPOL, CPHA, data_tx,
    output miso, miso_oe, tx_load, data_rx, rx_valid, rx_abort, busy
  );

  modport master (
    output cs, sclk, mosi, CPOL, CPHA, data_tx,
    input  miso, miso_oe, tx_load, data_rx, rx_valid, rx_abort, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus registered rise/fall detector for one
// asynchronous input; pulses appear 3 sys_clk cycles after the pad change.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic din_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, d3_q, rise_q, fall_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      d3_q   <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= din_i;
      s2_q   <= s1_q;
      d3_q   <= s2_q;
      rise_q <= s2_q & ~d3_q;
      fall_q <= ~s2_q & d3_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples cs/sclk/mosi in the sys_clk domain and
// exchanges MSB-first bytes in any CPOL/CPHA mode.
module spi_slave
  import spi_pkg::*;
(
  input  logic     sys_clk,
  input  logic     sys_rst_n,
  spi_slave_if.slave bus
);

  logic cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic mosi_s1_q, mosi_s_q;

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk_i   (sys_clk),
    .rst_n_i (sys_rst_n),
    .din_i   (bus.cs),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk_i   (sys_clk),
    .rst_n_i (sys_rst_n),
    .din_i   (bus.sclk),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mosi_s1_q <= 1'b0;
      mosi_s_q  <= 1'b0;
    end else begin
      mosi_s1_q <= bus.mosi;
      mosi_s_q  <= mosi_s1_q;
    end
  end

  spi_mode_e        mode;
  spi_state_e       state_q;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [SPI_W-1:0] rx_shift_q, rx_shift_d;
  logic [SPI_W-1:0] tx_shift_q, data_rx_q;
  logic             rx_valid_q, tx_load_q, rx_abort_q;
  logic             lead_edge, trail_edge, sample_ev, shift_ev;

  assign mode       = spi_mode_e'({bus.CPOL, bus.CPHA});
  assign lead_edge  = mode_cpol(mode) ? sclk_fall : sclk_rise;
  assign trail_edge = mode_cpol(mode) ? sclk_rise : sclk_fall;

  // A cs edge in the same cycle swallows any sclk edge.
  assign sample_ev  = (state_q == ACTIVE) && !cs_rise && !cs_fall &&
                      (mode_cpha(mode) ? trail_edge : lead_edge);
  assign shift_ev   = (state_q == ACTIVE) && !cs_rise && !cs_fall &&
                      (mode_cpha(mode) ? lead_edge : trail_edge);

  assign bit_cnt_d  = bit_cnt_q + 3'd1;
  assign rx_shift_d = {rx_shift_q[SPI_W-2:0], mosi_s_q};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      data_rx_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      rx_abort_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      rx_abort_q <= 1'b0;
      if (cs_fall) begin
        state_q    <= ACTIVE;
        bit_cnt_q  <= 3'd0;
        rx_shift_q <= '0;
        tx_shift_q <= bus.data_tx;
        tx_load_q  <= 1'b1;
      end else if (cs_rise) begin
        state_q    <= IDLE;
        rx_abort_q <= (bit_cnt_q != 3'd0);
        bit_cnt_q  <= 3'd0;
      end else if (sample_ev) begin
        rx_shift_q <= rx_shift_d;
        bit_cnt_q  <= bit_cnt_d;
        if (bit_cnt_q == 3'd7) begin
          data_rx_q  <= rx_shift_d;
          rx_valid_q <= 1'b1;
          tx_shift_q <= bus.data_tx;
          tx_load_q  <= 1'b1;
        end
      end else if (shift_ev && bit_cnt_q != 3'd0) begin
        // bit_cnt==0 guards the first CPHA=1 leading edge and the
        // CPHA=0 trailing edge right after a byte reload.
        tx_shift_q <= {tx_shift_q[SPI_W-2:0], 1'b0};
      end
    end
  end

  assign bus.miso     = tx_shift_q[SPI_W-1];
  assign bus.miso_oe  = (state_q == ACTIVE);
  assign bus.busy     = (state_q == ACTIVE);
  assign bus.data_rx  = data_rx_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_load  = tx_load_q;
  assign bus.rx_abort = rx_abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave: behavioural SPI master against a byte-level
// reference of what each frame must deliver in both directions.
module tb_spi_slave;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  spi_slave_if ifc();

  spi_slave dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (ifc.slave)
  );

  localparam int GAP = 8;

  int n_cmp = 0;
  int n_bad = 0;
  int rxv_cnt = 0, txl_cnt = 0, ab_cnt = 0, oe_cnt = 0;
  logic [7:0] rx_q[$];

  logic cpol = 1'b0, cpha = 1'b0;
  int   H = 4;
  logic [7:0] tb_mo[4];
  logic [7:0] tb_tx[5];
  logic [7:0] tb_got[4];
  logic [7:0] model_rx = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (ifc.rx_valid === 1'b1) begin
      rxv_cnt++;
      rx_q.push_back(ifc.data_rx);
    end
    if (ifc.tx_load === 1'b1)  txl_cnt++;
    if (ifc.rx_abort === 1'b1) ab_cnt++;
    if (ifc.miso_oe === 1'b1)  oe_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic set_mode(input logic c, input logic p, input int h);
    cpol = c; cpha = p; H = h;
    ifc.CPOL = c; ifc.CPHA = p; ifc.sclk = c;
    wait_cyc(GAP);
  endtask

  // One bit of the master: drive mosi, toggle sclk, capture miso on the sample edge.
  task automatic send_bit(input logic b, output logic r);
    if (!cpha) begin
      ifc.mosi = b;
      wait_cyc(H);
      ifc.sclk = ~cpol;
      r = ifc.miso;
      wait_cyc(H);
      ifc.sclk = cpol;
    end else begin
      ifc.sclk = ~cpol;
      ifc.mosi = b;
      wait_cyc(H);
      ifc.sclk = cpol;
      r = ifc.miso;
      wait_cyc(H);
    end
  endtask

  // Full cs frame of nbits bits; reference: every complete byte from the
  // master appears on data_rx in order, and the master gets tb_tx[0..] back.
  task automatic do_frame(input string tag, input int nbits);
    int full, r0, t0, a0, q0;
    logic rb;
    full = nbits / 8;
    r0 = rxv_cnt; t0 = txl_cnt; a0 = ab_cnt; q0 = rx_q.size();
    ifc.data_tx = tb_tx[0];
    ifc.cs = 1'b0;
    wait_cyc(GAP);
    ifc.data_tx = tb_tx[1];
    chk({tag, " busy_on"}, 32'(ifc.busy), 32'd1);
    chk({tag, " miso_idle"}, 32'(ifc.miso), 32'(tb_tx[0][7]));
    for (int i = 0; i < nbits; i++) begin
      if (i % 8 == 3 && i >= 8) ifc.data_tx = tb_tx[i/8 + 1];
      send_bit(tb_mo[i/8][7 - i%8], rb);
      tb_got[i/8][7 - i%8] = rb;
    end
    wait_cyc(H);
    ifc.cs = 1'b1;
    wait_cyc(GAP);
    chk({tag, " rx_valid_cnt"}, 32'(rxv_cnt - r0), 32'(full));
    chk({tag, " tx_load_cnt"}, 32'(txl_cnt - t0), 32'(full + 1));
    chk({tag, " rx_abort_cnt"}, 32'(ab_cnt - a0), (nbits % 8 != 0) ? 32'd1 : 32'd0);
    for (int b = 0; b < full; b++) begin
      if (q0 + b < rx_q.size())
        chk({tag, " rx_byte"}, 32'(rx_q[q0 + b]), 32'(tb_mo[b]));
      chk({tag, " master_byte"}, 32'(tb_got[b]), 32'(tb_tx[b]));
      model_rx = tb_mo[b];
    end
    chk({tag, " data_rx"}, 32'(ifc.data_rx), 32'(model_rx));
    chk({tag, " busy_off"}, 32'(ifc.busy), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " miso"},     32'(ifc.miso),     32'd0);
    chk({tag, " miso_oe"},  32'(ifc.miso_oe),  32'd0);
    chk({tag, " busy"},     32'(ifc.busy),     32'd0);
    chk({tag, " data_rx"},  32'(ifc.data_rx),  32'd0);
    chk({tag, " rx_valid"}, 32'(ifc.rx_valid), 32'd0);
    chk({tag, " tx_load"},  32'(ifc.tx_load),  32'd0);
    chk({tag, " rx_abort"}, 32'(ifc.rx_abort), 32'd0);
  endtask

  initial begin
    logic rb;
    int nb, nbits, r0, t0, o0;
    ifc.cs = 1'b1; ifc.sclk = 1'b0; ifc.mosi = 1'b0;
    ifc.CPOL = 1'b0; ifc.CPHA = 1'b0; ifc.data_tx = 8'h00;
    wait_cyc(3);
    chk_reset_outputs("reset");
    sys_rst_n = 1'b1;
    wait_cyc(4);

    set_mode(1'b0, 1'b0, 4);
    tb_mo[0] = 8'hA5; tb_tx[0] = 8'h3C; tb_tx[1] = 8'h3C;
    do_frame("mode0", 8);

    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0], 4);
      tb_mo[0] = 8'h81; tb_tx[0] = 8'h7E; tb_tx[1] = 8'h7E;
      do_frame($sformatf("mode%0d", m), 8);
    end

    set_mode(1'b0, 1'b0, 4);
    tb_mo[0] = 8'h12; tb_mo[1] = 8'h34;
    tb_tx[0] = 8'h9C; tb_tx[1] = 8'h56; tb_tx[2] = 8'h56;
    do_frame("b2b", 16);

    tb_mo[0] = 8'hB7; tb_tx[0] = 8'h11; tb_tx[1] = 8'h11;
    do_frame("abort5", 5);
    tb_mo[0] = 8'hF0; tb_tx[0] = 8'h22; tb_tx[1] = 8'h22;
    do_frame("after_abort", 8);

    set_mode(1'b1, 1'b1, 5);
    ifc.data_tx = 8'hC3;
    ifc.cs = 1'b0;
    wait_cyc(GAP);
    for (int i = 0; i < 3; i++) send_bit(1'b1, rb);
    sys_rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    wait_cyc(2);
    ifc.cs = 1'b1; ifc.sclk = cpol; ifc.mosi = 1'b0;
    wait_cyc(2);
    sys_rst_n = 1'b1;
    model_rx = 8'h00;
    wait_cyc(6);
    tb_mo[0] = 8'h55; tb_tx[0] = 8'hE4; tb_tx[1] = 8'hE4;
    do_frame("post_reset", 8);

    r0 = rxv_cnt; t0 = txl_cnt; o0 = oe_cnt;
    for (int i = 0; i < 16; i++) begin
      ifc.sclk = ~ifc.sclk;
      ifc.mosi = i[0];
      wait_cyc(H);
    end
    ifc.sclk = cpol;
    wait_cyc(GAP);
    chk("cs_high rx_valid_cnt", 32'(rxv_cnt - r0), 32'd0);
    chk("cs_high tx_load_cnt", 32'(txl_cnt - t0), 32'd0);
    chk("cs_high miso_oe_cycles", 32'(oe_cnt - o0), 32'd0);

    for (int f = 0; f < 20; f++) begin
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(4, 6)));
      nb = int'($urandom_range(1, 3));
      for (int b = 0; b < 4; b++) tb_mo[b] = 8'($urandom);
      for (int b = 0; b < 5; b++) tb_tx[b] = 8'($urandom);
      nbits = nb * 8;
      if ($urandom_range(0, 4) == 0) nbits = nbits - int'($urandom_range(1, 7));
      do_frame($sformatf("rand%0d", f), nbits);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
